dcache_controller: RTL and testbench
====================================

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have no parameters; geometry (16 sets, 2-way, 32-byte lines, 32-bit addresses) is fixed by package constants.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 cpu_addr_i  in  32  byte address of CPU access.
REQ-005 cpu_data_i  in  32  CPU store data.
REQ-006 cpu_MemRead_i  in  1  load request.
REQ-007 cpu_MemWrite_i  in  1  store request.
REQ-008 cpu_data_o  out  32  load data.
REQ-009 cpu_stall_o  out  1  pipeline stall.
REQ-010 mem_addr_o  out  32  line-aligned memory address.
REQ-011 mem_data_o  out  256  write-back line.
REQ-012 mem_enable_o  out  1  memory request valid.
REQ-013 mem_write_o  out  1  1 = write-back, 0 = line fill.
REQ-014 mem_data_i  in  256  fill line.
REQ-015 mem_ack_i  in  1  one-cycle completion pulse.
REQ-016 cache_addr_o  out  4  set index to SRAM.
REQ-017 cache_tag_o  out  25  {valid, dirty, tag[22:0]} to SRAM.
REQ-018 cache_data_o  out  256  line to SRAM.
REQ-019 cache_enable_o  out  1  SRAM access enable.
REQ-020 cache_write_o  out  1  SRAM write strobe.
REQ-021 cache_tag_i  in  25  hit-way tag, or the LRU victim's tag on miss.
REQ-022 cache_data_i  in  256  hit-way line, or the LRU victim's line on miss.
REQ-023 cache_hit_i  in  1  SRAM tag match with valid set.

Function
REQ-024 Address split: tag = addr[31:9], index = addr[8:5], word = addr[4:2]; cache_addr_o = index at all times.
REQ-025 req = MemRead | MemWrite; if both are asserted, the access is a store.
REQ-026 cpu_stall_o = (state==IDLE & req & ~cache_hit_i) | (state!=IDLE), combinational; a hit in IDLE costs zero stall cycles.
REQ-027 Read hit: cpu_data_o = word[word] of cache_data_i, combinational; cpu_data_o = 0 otherwise.
REQ-028 Write hit: cache_enable_o = cache_write_o = 1 for one cycle; cache_data_o = cache_data_i with the selected 32-bit word replaced by cpu_data_i; cache_tag_o = {1,1,tag}.
REQ-029 FSM states: IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
REQ-030 IDLE -> MISS when req & ~cache_hit_i.
REQ-031 MISS: if cache_tag_i[24] & cache_tag_i[23] (victim valid and dirty) -> WRITEBACK, registering mem_enable_o=1, mem_write_o=1, mem_addr_o={cache_tag_i[22:0],index,5'b0}, mem_data_o=cache_data_i; otherwise -> READMISS, registering mem_enable_o=1, mem_write_o=0, mem_addr_o={tag,index,5'b0}.
REQ-032 WRITEBACK: hold all mem_* outputs until mem_ack_i; on ack -> READMISS with a fill request as in REQ-031.
REQ-033 READMISS: hold the request until mem_ack_i; in the ack cycle: cache_enable_o=cache_write_o=1, cache_data_o=mem_data_i, cache_tag_o={1,0,tag}, mem_enable_o<=0; -> READMISSOK.
REQ-034 READMISSOK -> IDLE unconditionally; the retried access then hits; a store miss becomes a write hit (write-allocate), setting dirty.
REQ-035 mem_enable_o stays high continuously from MISS exit until the acknowledging cycle; memory latency is arbitrary (>=1 cycle); mem_ack_i outside WRITEBACK/READMISS is ignored.
REQ-036 cache_enable_o = cache_write_o = 0 in every case not covered by REQ-028 and REQ-033.

Reset
REQ-037 rst_i low immediately forces state=IDLE and mem_enable_o, mem_write_o, mem_addr_o, mem_data_o = 0, including mid-WRITEBACK/READMISS; the in-flight transaction is abandoned.
REQ-038 Combinational outputs follow REQ-026 to REQ-028 during reset with state=IDLE.

Structure
REQ-039 Shared package dcache_pkg SHALL hold the state enum, TAG_W=23, INDEX_W=4, OFFSET_W=5, LINE_W=256, and VALID_BIT=24, DIRTY_BIT=23.
REQ-040 Sub-module dcache_word_merge SHALL implement the word select (load) and word replace (store) on a 256-bit line.

Verification
REQ-041 Cold load 0x0000_0128, fill word2=0xDEADBEEF, ack after 10 cycles -> mem_addr_o=0x120, mem_write_o=0, stall through READMISSOK, then cpu_data_o=0xDEADBEEF with stall low.
REQ-042 Then store 0x12345678 to 0x0000_012C -> no stall, cache_write_o=1, cache_tag_o=25'h1800000, word3 replaced.
REQ-043 Fill 0x328, then load 0x528 with dirty LRU victim 0x120 -> WRITEBACK with mem_addr_o=0x120 and merged line, then fill from 0x520.
REQ-044 Miss with clean victim -> no mem_write_o=1 cycle; straight to READMISS.
REQ-045 rst_i low mid-READMISS -> mem_enable_o=0 without waiting for a clock edge, state=IDLE, and a late mem_ack_i is ignored.
REQ-046 mem_ack_i one cycle after request -> total miss stall of 4 cycles, then hit.

Source files
------------

// File: rtl/dcache_pkg.sv
// ============================================================================
// dcache_pkg : geometry constants, FSM state type and line-address helper
// Revision   : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dcache_pkg;
  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int TAG_W      = 23;
  localparam int INDEX_W    = 4;
  localparam int OFFSET_W   = 5;
  localparam int LINE_W     = 256;
  localparam int WORD_SEL_W = 3;
  localparam int WORDS      = LINE_W / WORD_W;
  localparam int CTAG_W     = 25;
  localparam int VALID_BIT  = 24;
  localparam int DIRTY_BIT  = 23;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MISS       = 3'd1,
    S_WRITEBACK  = 3'd2,
    S_READMISS   = 3'd3,
    S_READMISSOK = 3'd4
  } state_e;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                  input logic [INDEX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction
endpackage

`default_nettype wire

// File: rtl/dcache_controller_if.sv
// ============================================================================
// dcache_controller_if : CPU, memory and tag/data SRAM signals of the cache
// Revision             : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface dcache_controller_if;
  import dcache_pkg::*;

  logic [ADDR_W-1:0] cpu_addr_i;
  logic [WORD_W-1:0] cpu_data_i;
  logic              cpu_MemRead_i;
  logic              cpu_MemWrite_i;
  logic [WORD_W-1:0] cpu_data_o;
  logic              cpu_stall_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  logic [INDEX_W-1:0] cache_addr_o;
  logic [CTAG_W-1:0]  cache_tag_o;
  logic [LINE_W-1:0]  cache_data_o;
  logic               cache_enable_o;
  logic               cache_write_o;
  logic [CTAG_W-1:0]  cache_tag_i;
  logic [LINE_W-1:0]  cache_data_i;
  logic               cache_hit_i;

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    output cpu_data_o, cpu_stall_o,
    output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    input  mem_data_i, mem_ack_i,
    output cache_addr_o, cache_tag_o, cache_data_o, cache_enable_o, cache_write_o,
    input  cache_tag_i, cache_data_i, cache_hit_i
  );

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    input  cpu_data_o, cpu_stall_o,
    input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    output mem_data_i, mem_ack_i,
    input  cache_addr_o, cache_tag_o, cache_data_o, cache_enable_o, cache_write_o,
    output cache_tag_i, cache_data_i, cache_hit_i
  );
endinterface

`default_nettype wire

// File: rtl/dcache_word_merge.sv
// ============================================================================
// dcache_word_merge : selects one 32-bit word of a line and builds the line
//                     with that word replaced by store data
// Revision          : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0]     line_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0]     wdata_i,
  output logic [WORD_W-1:0]     rdata_o,
  output logic [LINE_W-1:0]     line_o
);
  logic [WORD_W-1:0] words [WORDS];

  for (genvar g = 0; g < WORDS; g++) begin : g_word
    assign words[g] = line_i[g*WORD_W +: WORD_W];
    assign line_o[g*WORD_W +: WORD_W] =
      (word_sel_i == WORD_SEL_W'(g)) ? wdata_i : words[g];
  end

  assign rdata_o = words[word_sel_i];
endmodule

`default_nettype wire

// File: rtl/dcache_controller.sv
// ============================================================================
// dcache_controller : 2-way, 16-set write-back / write-allocate data cache
//                     controller with single-line memory transactions
// Revision          : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dcache_controller
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  dcache_controller_if.slave bus
);
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_index;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  req;
  logic                  victim_dirty;
  logic [WORD_W-1:0]     load_word;
  logic [LINE_W-1:0]     merged_line;

  state_e            state_q, state_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;

  assign req_tag      = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign req_index    = bus.cpu_addr_i[OFFSET_W +: INDEX_W];
  assign req_word     = bus.cpu_addr_i[2 +: WORD_SEL_W];
  assign req          = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign victim_dirty = bus.cache_tag_i[VALID_BIT] & bus.cache_tag_i[DIRTY_BIT];

  dcache_word_merge u_word_merge (
    .line_i     (bus.cache_data_i),
    .word_sel_i (req_word),
    .wdata_i    (bus.cpu_data_i),
    .rdata_o    (load_word),
    .line_o     (merged_line)
  );

  assign bus.cache_addr_o = req_index;
  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;

  // Hits are served in IDLE with no stall; a store (even with MemRead set) wins.
  always_comb begin
    bus.cpu_stall_o    = (state_q != S_IDLE) | (req & ~bus.cache_hit_i);
    bus.cpu_data_o     = '0;
    bus.cache_enable_o = 1'b0;
    bus.cache_write_o  = 1'b0;
    bus.cache_tag_o    = '0;
    bus.cache_data_o   = '0;
    if (state_q == S_IDLE && bus.cache_hit_i) begin
      if (bus.cpu_MemWrite_i) begin
        bus.cache_enable_o = 1'b1;
        bus.cache_write_o  = 1'b1;
        bus.cache_tag_o    = {1'b1, 1'b1, req_tag};
        bus.cache_data_o   = merged_line;
      end else if (bus.cpu_MemRead_i) begin
        bus.cpu_data_o = load_word;
      end
    end else if (state_q == S_READMISS && bus.mem_ack_i) begin
      bus.cache_enable_o = 1'b1;
      bus.cache_write_o  = 1'b1;
      bus.cache_tag_o    = {1'b1, 1'b0, req_tag};
      bus.cache_data_o   = bus.mem_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (req && !bus.cache_hit_i) state_d = S_MISS;
      end
      S_MISS: begin
        mem_enable_d = 1'b1;
        if (victim_dirty) begin
          state_d     = S_WRITEBACK;
          mem_write_d = 1'b1;
          mem_addr_d  = line_addr(bus.cache_tag_i[TAG_W-1:0], req_index);
          mem_data_d  = bus.cache_data_i;
        end else begin
          state_d     = S_READMISS;
          mem_write_d = 1'b0;
          mem_addr_d  = line_addr(req_tag, req_index);
          mem_data_d  = '0;
        end
      end
      S_WRITEBACK: begin
        if (bus.mem_ack_i) begin
          state_d      = S_READMISS;
          mem_enable_d = 1'b1;
          mem_write_d  = 1'b0;
          mem_addr_d   = line_addr(req_tag, req_index);
          mem_data_d   = '0;
        end
      end
      S_READMISS: begin
        if (bus.mem_ack_i) begin
          state_d      = S_READMISSOK;
          mem_enable_d = 1'b0;
        end
      end
      S_READMISSOK: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_dcache_controller.sv
// ============================================================================
// tb_dcache_controller : directed and random checks of dcache_controller
//                        against a flat word-memory reference
// Revision             : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dcache_controller;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_controller_if bus();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing memory and flat reference memory, both defaulting to a fixed pattern
  logic [255:0] mem_line [int unsigned];
  logic [31:0]  ref_word [int unsigned];

  function automatic logic [255:0] line_init(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = (la << 12) ^ (32'h5A00_0000 | i);
    return l;
  endfunction

  function automatic logic [255:0] mem_get(input logic [31:0] la);
    if (mem_line.exists(la)) return mem_line[la];
    return line_init(la);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  wa;
    wa = {a[31:2], 2'b00};
    if (ref_word.exists(wa)) return ref_word[wa];
    l = line_init({a[31:5], 5'b0});
    return l[a[4:2]*32 +: 32];
  endfunction

  // Tag/data SRAM environment: 16 sets x 2 ways with one LRU bit per set
  logic [24:0]  tag_mem  [16][2];
  logic [255:0] data_mem [16][2];
  logic         lru      [16];
  logic         sram_hit, sram_way, sram_clear;

  always_comb begin
    sram_hit = 1'b0;
    sram_way = lru[bus.cache_addr_o];
    for (int w = 0; w < 2; w++)
      if (tag_mem[bus.cache_addr_o][w][24] &&
          tag_mem[bus.cache_addr_o][w][22:0] == bus.cpu_addr_i[31:9]) begin
        sram_hit = 1'b1;
        sram_way = w[0];
      end
    bus.cache_hit_i  = sram_hit;
    bus.cache_tag_i  = tag_mem[bus.cache_addr_o][sram_way];
    bus.cache_data_i = data_mem[bus.cache_addr_o][sram_way];
  end

  always @(posedge clk) begin
    if (sram_clear) begin
      for (int s = 0; s < 16; s++) begin
        lru[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          tag_mem[s][w]  <= '0;
          data_mem[s][w] <= '0;
        end
      end
    end else if (bus.cache_enable_o && bus.cache_write_o) begin
      tag_mem[bus.cache_addr_o][sram_way]  <= bus.cache_tag_o;
      data_mem[bus.cache_addr_o][sram_way] <= bus.cache_data_o;
      lru[bus.cache_addr_o]                <= ~sram_way;
    end else if ((bus.cpu_MemRead_i || bus.cpu_MemWrite_i) && sram_hit && !bus.cpu_stall_o) begin
      lru[bus.cache_addr_o] <= ~sram_way;
    end
  end

  function automatic logic predict_hit(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (tag_mem[a[8:5]][w][24] && tag_mem[a[8:5]][w][22:0] == a[31:9]) return 1'b1;
    return 1'b0;
  endfunction

  // Memory responder: acks the lat-th cycle of each request
  int           lat = 1;
  logic         resp_en = 1'b1;
  logic         resp_ack = 1'b0;
  logic         force_ack = 1'b0;
  int           cnt = 0;
  int           wb_count = 0, fill_count = 0, wb_cycles = 0;
  logic [31:0]  last_wb_addr = '0, last_fill_addr = '0;
  logic [255:0] last_wb_data = '0;

  assign bus.mem_ack_i = resp_ack | force_ack;

  initial begin
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (!resp_en || !rst_n) begin
        resp_ack = 1'b0;
        cnt      = 0;
      end else if (resp_ack) begin
        resp_ack = 1'b0;
        cnt      = 0;
      end else if (bus.mem_enable_o) begin
        if (bus.mem_write_o) wb_cycles++;
        cnt++;
        if (cnt >= lat) begin
          resp_ack = 1'b1;
          if (bus.mem_write_o) begin
            mem_line[bus.mem_addr_o] = bus.mem_data_o;
            last_wb_addr = bus.mem_addr_o;
            last_wb_data = bus.mem_data_o;
            wb_count++;
          end else begin
            bus.mem_data_i = mem_get(bus.mem_addr_o);
            last_fill_addr = bus.mem_addr_o;
            fill_count++;
          end
        end
      end
    end
  end

  logic         seen_we;
  logic [24:0]  seen_tag;
  logic [255:0] seen_line;
  logic [3:0]   seen_idx;

  // Starts and ends on a negedge; returns stall cycles and the hit-cycle outputs
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stalls, output logic [31:0] rdata);
    bus.cpu_addr_i     = addr;
    bus.cpu_data_i     = wdata;
    bus.cpu_MemRead_i  = rd;
    bus.cpu_MemWrite_i = wr;
    stalls = 0;
    #1;
    while (bus.cpu_stall_o && stalls < 300) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 300) check("stall_timeout", 1'b1, 1'b0);
    rdata     = bus.cpu_data_o;
    seen_we   = bus.cache_write_o;
    seen_tag  = bus.cache_tag_o;
    seen_line = bus.cache_data_o;
    seen_idx  = bus.cache_addr_o;
    @(negedge clk);
    bus.cpu_MemRead_i  = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int           st, wb0, fc0, wc0;
  logic [31:0]  rd_data, a, d;
  logic [255:0] exp_line;
  logic         wr, rdf, exp_hit;

  initial begin
    rst_n = 1'b0;
    sram_clear = 1'b1;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    bus.cpu_MemRead_i = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
    exp_line = line_init(32'h120);
    exp_line[95:64] = 32'hDEAD_BEEF;
    mem_line[32'h120] = exp_line;
    ref_word[32'h128] = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", bus.cpu_stall_o, 1'b0);
    check("rst_mem_enable", bus.mem_enable_o, 1'b0);
    check("rst_mem_write", bus.mem_write_o, 1'b0);
    check("rst_mem_addr", bus.mem_addr_o, 32'h0);
    check("rst_cache_enable", bus.cache_enable_o, 1'b0);
    check("rst_cpu_data", bus.cpu_data_o, 32'h0);
    @(negedge clk);
    sram_clear = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Cold load with a slow memory
    lat = 10;
    fc0 = fill_count;
    access(1'b1, 1'b0, 32'h128, 32'h0, st, rd_data);
    check("cold_stall", st, 13);
    check("cold_data", rd_data, 32'hDEAD_BEEF);
    check("cold_fill_addr", last_fill_addr, 32'h120);
    check("cold_fills", fill_count - fc0, 1);
    check("cold_no_wb", wb_cycles, 0);
    check("cold_index", seen_idx, 4'd9);
    check("cold_hit_no_write", seen_we, 1'b0);

    // Store hit with both strobes set
    lat = 2;
    access(1'b1, 1'b1, 32'h12C, 32'h1234_5678, st, rd_data);
    ref_word[32'h12C] = 32'h1234_5678;
    exp_line[127:96] = 32'h1234_5678;
    check("store_stall", st, 0);
    check("store_we", seen_we, 1'b1);
    check("store_tag", seen_tag, 25'h180_0000);
    check("store_line", seen_line, exp_line);

    // Dirty victim write-back, then clean-victim miss
    access(1'b1, 1'b0, 32'h328, 32'h0, st, rd_data);
    check("fill_328_data", rd_data, ref_read(32'h328));
    wb0 = wb_count;
    access(1'b1, 1'b0, 32'h528, 32'h0, st, rd_data);
    check("wb_count", wb_count - wb0, 1);
    check("wb_addr", last_wb_addr, 32'h120);
    check("wb_line", last_wb_data, exp_line);
    check("wb_fill_addr", last_fill_addr, 32'h520);
    check("wb_load_data", rd_data, ref_read(32'h528));
    wc0 = wb_cycles;
    access(1'b1, 1'b0, 32'h728, 32'h0, st, rd_data);
    check("clean_no_wb", wb_cycles - wc0, 0);
    check("clean_fill_addr", last_fill_addr, 32'h720);
    check("clean_load_data", rd_data, ref_read(32'h728));

    // Fastest memory: four stall cycles, then a plain hit
    lat = 1;
    access(1'b1, 1'b0, 32'h044, 32'h0, st, rd_data);
    check("fast_stall", st, 4);
    check("fast_data", rd_data, ref_read(32'h044));
    access(1'b1, 1'b0, 32'h044, 32'h0, st, rd_data);
    check("fast_hit_stall", st, 0);
    check("fast_hit_data", rd_data, ref_read(32'h044));

    // Reset mid-fill abandons the transaction; a late ack is ignored
    resp_en = 1'b0;
    bus.cpu_addr_i = 32'h0A0;
    bus.cpu_MemRead_i = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("pre_rst_req", bus.mem_enable_o, 1'b1);
    #1;
    rst_n = 1'b0;
    bus.cpu_MemRead_i = 1'b0;
    #1;
    check("async_rst_enable", bus.mem_enable_o, 1'b0);
    check("async_rst_addr", bus.mem_addr_o, 32'h0);
    check("async_rst_stall", bus.cpu_stall_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    force_ack = 1'b1;
    #1;
    check("late_ack_no_write", bus.cache_write_o, 1'b0);
    check("late_ack_stall", bus.cpu_stall_o, 1'b0);
    @(negedge clk);
    force_ack = 1'b0;
    #1;
    check("late_ack_enable", bus.mem_enable_o, 1'b0);
    check("late_ack_stall2", bus.cpu_stall_o, 1'b0);
    resp_en = 1'b1;
    @(negedge clk);

    // Random traffic over 4 tags x 4 sets to force conflicts and write-backs
    for (int n = 0; n < 250; n++) begin
      lat = $urandom_range(1, 4);
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5) |
          (32'($urandom_range(0, 7)) << 2);
      d = $urandom;
      wr = 1'($urandom_range(0, 1));
      rdf = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      exp_hit = predict_hit(a);
      access(rdf, wr, a, d, st, rd_data);
      check("rand_hit_no_stall", st == 0, exp_hit);
      if (!exp_hit) check("rand_miss_stall_min", st >= 4, 1'b1);
      if (wr) begin
        ref_word[a] = d;
        check("rand_store_we", seen_we, 1'b1);
        check("rand_store_tag", seen_tag, {2'b11, a[31:9]});
        check("rand_store_word", seen_line[a[4:2]*32 +: 32], d);
      end else begin
        check("rand_load_data", rd_data, ref_read(a));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
